zbb_count_unit: RTL
===================

Name: zbb_count_unit

Overview:
Multi-cycle execute-stage unit for the Zbb counting instructions CLZ, CTZ and CPOP.
- Sits between decode/issue and writeback, and consumes the output of the existing clz_encoder.
- CTZ is formed by bit-reversing the operand into clz_encoder.
- CPOP is accumulated iteratively, one byte per cycle.
- Valid/ready handshakes on both sides; a flush input kills in-flight work.

Parameters:
XLEN, 32, operand and result width (only 32 supported)
CPOP_CHUNK, 8, bits counted per CPOP iteration (must divide XLEN)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of any in-flight op; no result produced
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request this cycle
in_op  input  2  0=CLZ, 1=CTZ, 2=CPOP, 3=reserved
in_rs1  input  32  operand
in_rd  input  5  destination register tag, returned with result
out_valid  output  1  result valid
out_ready  input  1  writeback accepts result
out_result  output  32  zero-extended count (0..32)
out_rd  output  5  tag of the completed op

Behaviour:
- Reset state: IDLE, in_ready=1, out_valid=0, out_result=0, out_rd=0, accumulator=0, chunk counter=0.
- Handshake: a transfer occurs when valid&&ready on the same rising edge. Requests are accepted only in IDLE, so in_ready=(state==IDLE).
- FSM states: IDLE, ENC, CPOP, DONE.
- IDLE:
  - On accept, latch op, rs1 and rd.
  - op 0/1 -> ENC.
  - op 2 -> CPOP with accumulator=0 and counter=0.
  - op 3 -> DONE with result 0.
- ENC:
  - One cycle; register clz_encoder output, zero-extended to 32b.
  - CTZ feeds operand bit i from rs1[31-i].
  - Goes to DONE.
  - Latency accept->out_valid is 2 cycles.
- CPOP:
  - Each cycle adds the popcount of chunk [counter*8 +: 8] to a 6-bit accumulator; counter increments.
  - After chunk 3 -> DONE.
  - Latency is 5 cycles.
- DONE:
  - out_valid=1.
  - out_result and out_rd are held stable until out_ready.
  - On out_ready: -> IDLE; out_valid drops next cycle.
  - No new accept occurs in the DONE cycle (no bypass).
- Boundaries:
  - rs1=0: CLZ=32, CTZ=32, CPOP=0.
  - rs1=0xFFFFFFFF: CLZ=0, CTZ=0, CPOP=32.
  - The accumulator reaches 32 without wrap (6 bits).
- Flush:
  - Any state -> IDLE next cycle; out_valid=0 next cycle.
  - flush overrides a simultaneous accept, which is dropped.
  - flush in DONE discards the result even if out_ready=1 in that cycle.
- Reset mid-operation: same as flush, and all registers return to their reset values.
- Simultaneous reset and flush: reset wins; the result is identical.
- out_ready while not DONE is ignored.

Optional Feature:
Macro ZBB_CPOP_SINGLE_CYCLE_EN.
- Defined: CPOP uses a full 32-bit adder tree and behaves like ENC (one cycle, 2-cycle latency); the CPOP state and counter are removed.
- Undefined: the iterative 4-cycle CPOP described above.
- CLZ/CTZ timing and all handshakes are identical in both builds.

Decomposition:
- Shared package zbb_pkg holds:
  - op encodings OP_CLZ=2'd0, OP_CTZ=2'd1, OP_CPOP=2'd2;
  - state encodings;
  - XLEN and COUNT_W=6.
- Instantiates the existing clz_encoder (32-bit in, 6-bit out, 32 for zero input).
- One natural new sub-module, popcount8: combinational 8-bit -> 4-bit count, reused by both build variants.

Test Plan:
- Reset, then CLZ rs1=0x01800000, out_ready=1 -> out_valid 2 cycles after accept, out_result=7, out_rd echoed.
- CTZ rs1=0x0F31C7B0 -> 4; CTZ rs1=0x2F01C622 -> 1; CTZ rs1=0 -> 32; CLZ rs1=0xFFFFFFFF -> 0.
- CPOP rs1=0xFFFFFFFF -> 32 after 5 cycles (2 cycles with ZBB_CPOP_SINGLE_CYCLE_EN); CPOP rs1=0x80000001 -> 2; in_ready=0 throughout.
- Backpressure: out_ready=0 for 4 cycles after a CLZ result -> out_valid, out_result and out_rd stable; a second in_valid is not accepted until 1 cycle after the result handshake.
- Flush asserted mid-CPOP (cycle 2) with in_valid=1 -> no out_valid; unit IDLE next cycle; a following CLZ rs1=0x00000001 yields 31.
- Reset asserted in DONE with out_ready=1 -> out_valid=0 and out_result=0 on the next cycle; no handshake counted.

Source files
------------

// File: rtl/zbb_pkg.sv
// Shared encodings for the Zbb counting unit (CLZ/CTZ/CPOP).
// Optional build macro: ZBB_CPOP_SINGLE_CYCLE_EN.
package zbb_pkg;

  localparam int XLEN       = 32;
  localparam int COUNT_W    = 6;
  localparam int CPOP_CHUNK = 8;
  localparam int CHUNKS     = XLEN / CPOP_CHUNK;

  localparam logic [1:0] OP_CLZ  = 2'd0;
  localparam logic [1:0] OP_CTZ  = 2'd1;
  localparam logic [1:0] OP_CPOP = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_CPOP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/clz_encoder.sv
// Leading-zero count of a 32-bit word; all-zero input yields 32.
// Highest set bit wins because later loop iterations overwrite earlier ones.
module clz_encoder
  import zbb_pkg::*;
(
  input  logic [XLEN-1:0]    operand,
  output logic [COUNT_W-1:0] count
);

  always_comb begin
    count = COUNT_W'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (operand[i]) count = COUNT_W'(XLEN - 1 - i);
    end
  end

endmodule

// File: rtl/zbb_count_unit_popcount8.sv
// Combinational population count of one 8-bit chunk.
module popcount8 (
  input  logic [7:0] bits,
  output logic [3:0] count
);

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'd0, bits[i]};
    end
  end

endmodule

// File: rtl/zbb_count_unit.sv
// Multi-cycle CLZ/CTZ/CPOP execute unit with valid/ready on both sides.
// ZBB_CPOP_SINGLE_CYCLE_EN selects a one-cycle CPOP adder tree.
module zbb_count_unit
  import zbb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  logic [1:0]         state;
  logic [1:0]         op;
  logic [XLEN-1:0]    rs1;
  logic [4:0]         rd;
  logic [XLEN-1:0]    result;
  logic [XLEN-1:0]    rev;
  logic [XLEN-1:0]    enc_in;
  logic [COUNT_W-1:0] enc;

  always_comb begin
    rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      rev[i] = rs1[XLEN-1-i];
    end
  end

  // CTZ is CLZ of the bit-reversed operand
  assign enc_in = (op == OP_CTZ) ? rev : rs1;

  clz_encoder u_clz (
    .operand (enc_in),
    .count   (enc)
  );

`ifdef ZBB_CPOP_SINGLE_CYCLE_EN
  logic [3:0]         pc [CHUNKS];
  logic [COUNT_W-1:0] cpop;

  for (genvar g = 0; g < CHUNKS; g++) begin : g_pc
    popcount8 u_pc (
      .bits  (rs1[g*CPOP_CHUNK +: CPOP_CHUNK]),
      .count (pc[g])
    );
  end

  always_comb begin
    cpop = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      cpop = cpop + {2'd0, pc[i]};
    end
  end
`else
  logic [COUNT_W-1:0] acc;
  logic [1:0]         cnt;
  logic [3:0]         pc;
  logic [COUNT_W-1:0] acc_next;

  popcount8 u_pc (
    .bits  (rs1[{cnt, 3'b000} +: CPOP_CHUNK]),
    .count (pc)
  );

  assign acc_next = acc + {2'd0, pc};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op     <= '0;
      rs1    <= '0;
      rd     <= '0;
      result <= '0;
`ifndef ZBB_CPOP_SINGLE_CYCLE_EN
      acc    <= '0;
      cnt    <= '0;
`endif
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op  <= in_op;
            rs1 <= in_rs1;
            rd  <= in_rd;
            case (in_op)
              OP_CLZ, OP_CTZ: state <= S_ENC;
`ifdef ZBB_CPOP_SINGLE_CYCLE_EN
              OP_CPOP: state <= S_ENC;
`else
              OP_CPOP: begin
                state <= S_CPOP;
                acc   <= '0;
                cnt   <= '0;
              end
`endif
              default: begin
                state  <= S_DONE;
                result <= '0;
              end
            endcase
          end
        end
        S_ENC: begin
`ifdef ZBB_CPOP_SINGLE_CYCLE_EN
          if (op == OP_CPOP) result <= XLEN'(cpop);
          else               result <= XLEN'(enc);
`else
          result <= XLEN'(enc);
`endif
          state <= S_DONE;
        end
`ifndef ZBB_CPOP_SINGLE_CYCLE_EN
        S_CPOP: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(CHUNKS - 1)) begin
            result <= XLEN'(acc_next);
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = result;
  assign out_rd     = rd;

endmodule
